// File: rtl/load_store_unit_pkg.sv
// Shared constants and helpers for the SiMPLE data-memory master:
// RV32I load/store funct3 encodings, FSM states and request decoding.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } load_store_state_t;

    // Exactly one direction, a funct3 valid for that direction, natural alignment.
    function automatic logic request_legal(input logic is_load, input logic is_store,
                                           input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic f3_ok;
        logic align_ok;
        case (funct3)
            F3_B:    begin f3_ok = 1'b1;    align_ok = 1'b1;               end
            F3_H:    begin f3_ok = 1'b1;    align_ok = ~addr_lo[0];        end
            F3_W:    begin f3_ok = 1'b1;    align_ok = (addr_lo == 2'b00); end
            F3_BU:   begin f3_ok = is_load; align_ok = 1'b1;               end
            F3_HU:   begin f3_ok = is_load; align_ok = ~addr_lo[0];        end
            default: begin f3_ok = 1'b0;    align_ok = 1'b0;               end
        endcase
        return (is_load ^ is_store) & f3_ok & align_ok;
    endfunction

    function automatic logic [3:0] store_strobes(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] strobes;
        case (funct3[1:0])
            2'b00:   strobes = 4'b0001 << addr_lo;
            2'b01:   strobes = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: strobes = 4'b1111;
        endcase
        return strobes;
    endfunction

    // Replicating the low bytes across lanes lets the target pick any strobed lane.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_store_unit_load_data_aligner.sv
// Selects the addressed byte/halfword/word from a 32-bit read word and
// sign- or zero-extends it according to the RV32I load funct3.
module load_data_aligner
    import load_store_unit_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted_s;

    // Lane select by shifting the addressed byte down to bit 0, then extend.
    always_comb begin
        shifted_s = read_data >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    result = read_data;
            F3_BU:   result = {24'h000000, shifted_s[7:0]};
            F3_HU:   result = {16'h0000, shifted_s[15:0]};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory master: accepts one load/store from execute, runs a
// wait-state bus access, and returns the extended load result for writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_store_data,
    output logic                  stall,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic                  bus_read_enable,
    output logic                  bus_write_enable,
    output logic [3:0]            bus_byte_enable,
    output logic [DATA_WIDTH-1:0] bus_write_data,
    input  logic [DATA_WIDTH-1:0] bus_read_data,
    input  logic                  bus_ready
);

    load_store_state_t     state_r;
    load_store_state_t     state_next_s;
    logic [1:0]            addr_lo_r;
    logic [2:0]            funct3_r;
    logic                  is_store_r;
    logic                  done_r;
    logic                  error_r;
    logic [DATA_WIDTH-1:0] load_data_r;
    logic [ADDR_WIDTH-1:0] bus_address_r;
    logic                  bus_read_enable_r;
    logic                  bus_write_enable_r;
    logic [3:0]            bus_byte_enable_r;
    logic [DATA_WIDTH-1:0] bus_write_data_r;
    logic                  req_any_s;
    logic                  legal_s;
    logic [31:0]           aligned_s;

    assign req_any_s = req_load | req_store;
    assign legal_s   = request_legal(req_load, req_store, req_funct3, req_address[1:0]);

    load_data_aligner u_aligner (
        .read_data (bus_read_data),
        .addr_lo   (addr_lo_r),
        .funct3    (funct3_r),
        .result    (aligned_s)
    );

    // Next-state: illegal requests skip the bus and report straight away.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    state_next_s = legal_s ? ACCESS : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (bus_ready) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, request latch, bus drive registers and load result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r            <= IDLE;
            addr_lo_r          <= 2'b00;
            funct3_r           <= 3'b000;
            is_store_r         <= 1'b0;
            done_r             <= 1'b0;
            error_r            <= 1'b0;
            load_data_r        <= {DATA_WIDTH{1'b0}};
            bus_address_r      <= {ADDR_WIDTH{1'b0}};
            bus_read_enable_r  <= 1'b0;
            bus_write_enable_r <= 1'b0;
            bus_byte_enable_r  <= 4'b0000;
            bus_write_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE);
            error_r <= (state_r == IDLE) && req_any_s && !legal_s;
            case (state_r)
                IDLE: begin
                    if (req_any_s) begin
                        addr_lo_r  <= req_address[1:0];
                        funct3_r   <= req_funct3;
                        is_store_r <= req_store;
                        if (legal_s) begin
                            bus_address_r      <= {req_address[ADDR_WIDTH-1:2], 2'b00};
                            bus_read_enable_r  <= req_load;
                            bus_write_enable_r <= req_store;
                            bus_byte_enable_r  <= req_store ? store_strobes(req_funct3, req_address[1:0])
                                                            : 4'b1111;
                            bus_write_data_r   <= req_store ? store_lanes(req_funct3, req_store_data)
                                                            : {DATA_WIDTH{1'b0}};
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ready) begin
                        bus_address_r      <= {ADDR_WIDTH{1'b0}};
                        bus_read_enable_r  <= 1'b0;
                        bus_write_enable_r <= 1'b0;
                        bus_byte_enable_r  <= 4'b0000;
                        bus_write_data_r   <= {DATA_WIDTH{1'b0}};
                        if (!is_store_r) begin
                            load_data_r <= aligned_s;
                        end
                    end
                end
                DONE: begin
                    is_store_r <= is_store_r;
                end
                default: begin
                    is_store_r <= 1'b0;
                end
            endcase
        end
    end

    // The pipeline stalls from the request cycle itself, so stall cannot wait a cycle.
    assign stall            = (state_r == ACCESS) || ((state_r == IDLE) && req_any_s);
    assign done             = done_r;
    assign error            = error_r;
    assign load_data        = load_data_r;
    assign bus_address      = bus_address_r;
    assign bus_read_enable  = bus_read_enable_r;
    assign bus_write_enable = bus_write_enable_r;
    assign bus_byte_enable  = bus_byte_enable_r;
    assign bus_write_data   = bus_write_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every
// output each cycle; literal checks pin the model on hand-worked cases.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_store_data = 32'h0;
    logic [31:0] bus_read_data = 32'h0;
    logic        bus_ready = 1'b0;
    logic        stall, done, error;
    logic [31:0] load_data, bus_address, bus_write_data;
    logic        bus_read_enable, bus_write_enable;
    logic [3:0]  bus_byte_enable;

    load_store_unit dut (
        .clock(clock), .reset(reset), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
        .stall(stall), .done(done), .error(error), .load_data(load_data),
        .bus_address(bus_address), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_byte_enable(bus_byte_enable),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data), .bus_ready(bus_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    logic        exp_stall, exp_done, exp_error, exp_re, exp_we, exp_chk_bus, exp_chk_wd;
    logic [31:0] exp_addr, exp_wd;
    logic [31:0] exp_ld = 32'h0;
    logic [3:0]  exp_be;

    int          req_cyc, re_cnt, we_cnt, stall_cnt, done_cyc, err_seen;
    logic [31:0] seen_addr, seen_wd;
    logic [3:0]  seen_be;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic logic m_legal(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
        int size;
        if (ld == st) return 1'b0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        logic [3:0] be;
        size = 1 << f3[1:0];
        if (!st) be = 4'hF;
        else     be = 4'((1 << size) - 1) << a[1:0];
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
        int size;
        logic [31:0] wd;
        size = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % size) +: 8];
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        int size;
        logic [31:0] v, mask;
        size = 1 << f3[1:0];
        v = w >> (8 * int'(a[1:0]));
        if (size < 4) begin
            mask = (32'd1 << (8 * size)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8*size-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (check_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("done", 32'(done), 32'(exp_done));
            chk("error", 32'(error), 32'(exp_error));
            chk("bus_read_enable", 32'(bus_read_enable), 32'(exp_re));
            chk("bus_write_enable", 32'(bus_write_enable), 32'(exp_we));
            chk("load_data", load_data, exp_ld);
            if (exp_chk_bus) begin
                chk("bus_address", bus_address, exp_addr);
                chk("bus_byte_enable", 32'(bus_byte_enable), 32'(exp_be));
            end
            if (exp_chk_wd) chk("bus_write_data", bus_write_data, exp_wd);
            if (bus_read_enable) re_cnt++;
            if (bus_write_enable) we_cnt++;
            if (stall) stall_cnt++;
            if (done) done_cyc = cyc;
            if (done && error) err_seen = 1;
            if (bus_read_enable || bus_write_enable) begin
                seen_addr = bus_address;
                seen_be   = bus_byte_enable;
                seen_wd   = bus_write_data;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic dn, input logic er, input logic re,
                           input logic we, input logic cb, input logic [31:0] ad,
                           input logic [3:0] be, input logic cw, input logic [31:0] wd);
        exp_stall = s;  exp_done = dn; exp_error = er; exp_re = re; exp_we = we;
        exp_chk_bus = cb; exp_addr = ad; exp_be = be; exp_chk_wd = cw; exp_wd = wd;
    endtask

    task automatic clear_obs();
        req_cyc = cyc; re_cnt = 0; we_cnt = 0; stall_cnt = 0; done_cyc = -1; err_seen = 0;
    endtask

    task automatic idle_cycle();
        step();
        req_load = 1'b0; req_store = 1'b0; bus_ready = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    // One full transaction; the request stays up through DONE, where it must be ignored.
    task automatic txn(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int waits, input logic [31:0] rdata);
        logic legal;
        legal = m_legal(ld, st, f3, a);
        step();
        req_load = ld; req_store = st; req_funct3 = f3; req_address = a; req_store_data = d;
        bus_ready = 1'b1; bus_read_data = 32'hBAD0_BAD0;
        clear_obs();
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        if (legal) begin
            for (int w = 0; w <= waits; w++) begin
                step();
                bus_ready = (w == waits);
                bus_read_data = (w == waits) ? rdata : 32'h5A5A_5A5A;
                set_exp(1'b1, 1'b0, 1'b0, ld, st, 1'b1, {a[31:2], 2'b00}, m_be(st, f3, a),
                        st, m_wd(f3, d));
            end
        end
        step();
        bus_ready = 1'b1; bus_read_data = 32'hFFFF_FFFF;
        if (legal && ld) exp_ld = m_load(f3, a, rdata);
        set_exp(1'b0, 1'b1, !legal, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clock);
        #1;
    endtask

    initial begin
        // Reset held across two edges; every output must read zero.
        step();
        check_en = 1'b1;
        exp_ld = 32'h0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        step();
        reset = 1'b1;
        idle_cycle();

        // LW 0x100, zero wait states.
        txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        chk("lw_load_data", load_data, 32'hDEAD_BEEF);
        chk("lw_re_cycles", 32'(re_cnt), 32'd1);
        chk("lw_bus_address", seen_addr, 32'h100);
        chk("lw_done_cycle", 32'(done_cyc - req_cyc), 32'd2);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd2);

        txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234);
        chk("lb_load_data", load_data, 32'hFFFF_FF80);
        txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_1234);
        chk("lbu_load_data", load_data, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80FF_1234);
        chk("lhu_load_data", load_data, 32'h0000_80FF);
        txn(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_1234);

        // SB 0x201 with two wait states; load_data must hold.
        txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00A5, 2, 32'h0);
        chk("sb_byte_enable", 32'(seen_be), 32'h2);
        chk("sb_write_data", seen_wd, 32'hA5A5_A5A5);
        chk("sb_bus_address", seen_addr, 32'h200);
        chk("sb_we_cycles", 32'(we_cnt), 32'd3);
        chk("sb_done_cycle", 32'(done_cyc - req_cyc), 32'd4);
        txn(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234_BEEF, 1, 32'h0);
        chk("sh_write_data", seen_wd, 32'hBEEF_BEEF);

        // Illegal requests: misaligned, bad funct3, both directions.
        txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        chk("lw_mis_done_cycle", 32'(done_cyc - req_cyc), 32'd1);
        chk("lw_mis_error", 32'(err_seen), 32'd1);
        chk("lw_mis_no_bus", 32'(re_cnt + we_cnt), 32'd0);
        txn(1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 0, 32'h0);
        chk("f3_011_error", 32'(err_seen), 32'd1);
        txn(1'b1, 1'b1, 3'b010, 32'h108, 32'h0, 0, 32'h0);
        chk("both_error", 32'(err_seen), 32'd1);
        chk("both_no_bus", 32'(re_cnt + we_cnt), 32'd0);
        txn(1'b0, 1'b1, 3'b100, 32'h10C, 32'h0, 0, 32'h0);
        txn(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0);
        idle_cycle();

        // Reset during a stalled read: abandoned without a done pulse.
        step();
        req_load = 1'b1; req_funct3 = 3'b010; req_address = 32'h40; bus_ready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        step();
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 4'hF, 1'b0, 32'h0);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1; req_load = 1'b0;
        clear_obs();
        exp_ld = 32'h0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        idle_cycle();
        idle_cycle();
        @(negedge clock);
        #1;
        chk("reset_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

        txn(1'b0, 1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, 0, 32'h0);
        chk("sw_byte_enable", 32'(seen_be), 32'hF);
        chk("sw_write_data", seen_wd, 32'hCAFE_F00D);
        txn(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 3, 32'h7654_3210);
        chk("lhu_hi_load_data", load_data, 32'h0000_7654);
        idle_cycle();
        @(negedge clock);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
